// File: rtl/serial_tc_pkg.sv
// Shared mode encodings and sizing helper for the bit-serial two's-complement unit.
package serial_tc_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_NEG  = 2'b01;
    localparam logic [1:0] MODE_ABS  = 2'b10;

    // Width of a counter that indexes bits 0..w-1 of a word.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_tc_lane.sv
// One serial channel: whole-word capture buffer, result buffer, and the
// "pass up to first 1, invert afterwards" two's-complement bit stage.
module serial_tc_lane
    import serial_tc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic beat,
    input  logic last,
    input  logic out_en,
    input  logic first,
    input  logic msb,
    input  logic neg,
    input  logic abs_mode,
    input  logic din,
    output logic dout,
    output logic ovf
);

    logic [W-1:0] in_sr;
    logic [W-1:0] out_sr;
    logic [W-1:0] word_nxt;
    logic         sign;
    logic         seen;
    logic         seen_eff;
    logic         inv;
    logic         b;

    assign word_nxt = {din, in_sr[W-1:1]};
    assign b        = out_sr[0];
    assign seen_eff = seen & ~first;
    // Abs needs the sign of the whole buffered word, so it is held per lane.
    assign inv      = neg | (abs_mode & sign);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_sr  <= '0;
            out_sr <= '0;
            sign   <= 1'b0;
            seen   <= 1'b0;
            dout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (beat) begin
            in_sr <= word_nxt;
            if (out_en) begin
                dout   <= b ^ (inv & seen_eff);
                seen   <= seen_eff | b;
                ovf    <= msb & inv & b & ~seen_eff;
                out_sr <= out_sr >> 1;
            end else begin
                ovf <= 1'b0;
            end
            // The load on the last input bit overrides the shift of the old word.
            if (last) begin
                out_sr <= word_nxt;
                sign   <= din;
            end
        end
    end

endmodule

// File: rtl/serial_tc_negate_mc.sv
// Multi-channel bit-serial pass/negate/abs unit: shared word framing, mode
// latching and output strobes, with one serial_tc_lane per channel.
module serial_tc_negate_mc
    import serial_tc_pkg::*;
#(
    parameter int W  = 8,
    parameter int CH = 2
) (
    input  logic          t_clk,
    input  logic          r_n,
    input  logic          i_vld,
    input  logic          i_sow,
    input  logic [1:0]    i_mode,
    input  logic [CH-1:0] i_dat,
    output logic          o_vld,
    output logic          o_sow,
    output logic [CH-1:0] o_dat,
    output logic [CH-1:0] o_ovf
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] b_idx;
    logic          primed;
    logic [1:0]    mode_in;
    logic [1:0]    mode_out;
    logic          resync;
    logic          last;
    logic          out_en;
    logic          first;
    logic          msb;
    logic          neg;
    logic          abs_mode;

    // i_sow on a beat forces bit 0; mid-word it abandons the partial word.
    assign b_idx    = i_sow ? '0 : bit_cnt;
    assign resync   = i_vld & i_sow & (bit_cnt != '0);
    assign last     = i_vld & (b_idx == LAST_IDX);
    assign out_en   = i_vld & primed & ~resync;
    assign first    = (b_idx == '0);
    assign msb      = (b_idx == LAST_IDX);
    assign neg      = (mode_out == MODE_NEG);
    assign abs_mode = (mode_out == MODE_ABS);

    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            bit_cnt  <= '0;
            primed   <= 1'b0;
            mode_in  <= MODE_PASS;
            mode_out <= MODE_PASS;
            o_vld    <= 1'b0;
            o_sow    <= 1'b0;
        end else begin
            o_vld <= out_en;
            o_sow <= out_en & first;
            if (i_vld) begin
                bit_cnt <= last ? '0 : b_idx + CW'(1);
                if (first) mode_in <= i_mode;
                if (resync) primed <= 1'b0;
                if (last) begin
                    primed   <= 1'b1;
                    mode_out <= mode_in;
                end
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        serial_tc_lane #(.W(W)) u_lane (
            .clk      (t_clk),
            .rst_n    (r_n),
            .beat     (i_vld),
            .last     (last),
            .out_en   (out_en),
            .first    (first),
            .msb      (msb),
            .neg      (neg),
            .abs_mode (abs_mode),
            .din      (i_dat[c]),
            .dout     (o_dat[c]),
            .ovf      (o_ovf[c])
        );
    end

endmodule
